truth_table_sweeper: RTL and testbench

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_sweeper.sv | 117 +++++++++++
 tb/tb_truth_table_sweeper.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives every input vector for DWELL cycles and counts output mismatches.
// Optional macro SWEEP_GRAY_EN selects Gray-code vector order instead of binary order.
module truth_table_sweeper #(
    parameter int unsigned        N      = 4,
    parameter int unsigned        DWELL  = 2,
    parameter logic [2**N-1:0]    EXPECT = 16'hA5C3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         dut_f,
    output logic [N-1:0] vec,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_cnt,
    output logic         fail_seen,
    output logic [N-1:0] first_fail
);

    localparam int unsigned     DW_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DW_LAST  = DW_W'(DWELL - 1);
    localparam logic [N-1:0]    IDX_LAST = '1;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } state_t;

    state_t          state_q;
    logic [N-1:0]    idx_q;
    logic [N-1:0]    idx_d;
    logic [N-1:0]    vec_d;
    logic [DW_W-1:0] dwell_q;
    logic            last_q;
    logic            mismatch;
    logic [N:0]      err_d;

    function automatic logic [N-1:0] encode(input logic [N-1:0] i);
`ifdef SWEEP_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    // err_cnt saturates at 2**N, the point where its MSB first becomes set
    always_comb begin
        idx_d    = idx_q + 1'b1;
        vec_d    = encode(idx_d);
        mismatch = (dut_f != EXPECT[vec]);
        err_d    = err_cnt[N] ? err_cnt : err_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            dwell_q    <= '0;
            last_q     <= 1'b0;
            vec        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_seen  <= 1'b0;
            first_fail <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= APPLY;
                        idx_q      <= '0;
                        dwell_q    <= '0;
                        last_q     <= 1'b0;
                        vec        <= encode('0);
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_cnt    <= '0;
                        fail_seen  <= 1'b0;
                        first_fail <= '0;
                    end
                end
                APPLY: begin
                    // One extra APPLY cycle after the final sample lets err_cnt settle before pass is taken
                    if (last_q) begin
                        state_q <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_cnt == '0);
                    end else if (dwell_q == DW_LAST) begin
                        dwell_q <= '0;
                        if (mismatch) begin
                            err_cnt <= err_d;
                            if (!fail_seen) begin
                                fail_seen  <= 1'b1;
                                first_fail <= vec;
                            end
                        end
                        if (idx_q == IDX_LAST) begin
                            last_q <= 1'b1;
                        end else begin
                            idx_q <= idx_d;
                            vec   <= vec_d;
                        end
                    end else begin
                        dwell_q <= dwell_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: randomized response tables against a reference sweep model.
// Honors SWEEP_GRAY_EN in the model so the same bench covers both vector orders.
module tb_truth_table_sweeper;

    localparam int          N     = 4;
    localparam int          DWELL = 2;
    localparam int          NV    = 16;
    localparam int          LAT   = NV * DWELL + 1;
    localparam logic [15:0] EXP_P = 16'hA5C3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         dut_f;
    logic [N-1:0] vec;
    logic         busy;
    logic         done;
    logic         pass;
    logic [N:0]   err_cnt;
    logic         fail_seen;
    logic [N-1:0] first_fail;

    logic [15:0]  exp_tt   = 16'hA5C3;
    logic [15:0]  resp_tbl = 16'hA5C3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sweep_c0 = -1;
    bit done_prev = 1'b0;

    typedef struct {
        int err;
        int ff;
        int fs;
        int ps;
        int done_cyc;
    } exp_t;

    exp_t sb[$];

    truth_table_sweeper #(.N(N), .DWELL(DWELL), .EXPECT(EXP_P)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dut_f      (dut_f),
        .vec        (vec),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .fail_seen  (fail_seen),
        .first_fail (first_fail)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always_comb dut_f = resp_tbl[vec];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int enc(input int i);
`ifdef SWEEP_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    // Walk the application order, compare the responding table with the golden table
    function automatic exp_t predict(input logic [15:0] tbl, input int c0);
        exp_t e;
        e.err = 0; e.ff = 0; e.fs = 0;
        for (int i = 0; i < NV; i++) begin
            int v;
            v = enc(i);
            if (tbl[v] != exp_tt[v]) begin
                e.err++;
                if (e.fs == 0) begin
                    e.fs = 1;
                    e.ff = v;
                end
            end
        end
        e.ps = (e.err == 0) ? 1 : 0;
        e.done_cyc = c0 + LAT;
        return e;
    endfunction

    always @(negedge clk) begin
        int k;
        int idx;
        exp_t e;
        if (rst_n) begin
            if (busy && sweep_c0 >= 0) begin
                k = cyc - sweep_c0;
                idx = k / DWELL;
                if (idx > NV - 1) idx = NV - 1;
                check("vec_seq", int'(vec), enc(idx));
                check("done_while_busy", int'(done), 0);
            end
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no sweep pending (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("latency", cyc, e.done_cyc);
                    check("err_cnt", int'(err_cnt), e.err);
                    check("fail_seen", int'(fail_seen), e.fs);
                    check("first_fail", int'(first_fail), e.ff);
                    check("pass", int'(pass), e.ps);
                    check("busy_at_done", int'(busy), 0);
                end
                sweep_c0 = -1;
            end
            done_prev = done;
        end else begin
            done_prev = 1'b0;
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        sweep_c0 = cyc + 1;
        sb.push_back(predict(resp_tbl, cyc + 1));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4 * LAT; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=0 expected done within %0d cycles", 4 * LAT);
            sb.delete();
        end
    endtask

    task automatic run_sweep(input logic [15:0] tbl);
        resp_tbl = tbl;
        do_start();
        wait_done();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check("done_held", int'(done), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vec"}, int'(vec), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pass"}, int'(pass), 0);
        check({tag, "_err"}, int'(err_cnt), 0);
        check({tag, "_fs"}, int'(fail_seen), 0);
        check({tag, "_ff"}, int'(first_fail), 0);
    endtask

    initial begin
        bit done_rose;
        logic [15:0] mask;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(exp_tt);
        run_sweep(16'h0000);
        run_sweep(16'hFFFF);

        for (int t = 0; t < 8; t++) begin
            mask = 16'($urandom) & 16'($urandom);
            run_sweep(exp_tt ^ mask);
        end

        // Second start mid-sweep must be ignored
        resp_tbl = exp_tt ^ 16'h0100;
        do_start();
        while (cyc < sweep_c0 + 4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);

        // Reset in the middle of a sweep aborts it
        resp_tbl = exp_tt;
        do_start();
        while (cyc < sweep_c0 + 10) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        sweep_c0 = -1;
        @(negedge clk);
        check_all_zero("abort");
        rst_n = 1'b1;
        done_rose = 1'b0;
        repeat (2 * LAT) begin
            @(negedge clk);
            if (done) done_rose = 1'b1;
        end
        check("no_done_after_abort", int'(done_rose), 0);

        run_sweep(exp_tt);
        run_sweep(exp_tt ^ 16'h8001);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
